// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and defaults for the circular-BIST controller
package bist_pkg;

  localparam int DEF_TEST_CYCLES = 16;
  localparam int DEF_SIG_WIDTH = 8;
  localparam logic [7:0] DEF_GOLDEN_SIG = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  // Width of a down-counter able to hold 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bist_controller_if.sv
// rtl/bist_controller_if.sv - request/result bundle between the arbiter path and the BIST controller
interface bist_controller_if
  import bist_pkg::*;
#(
  parameter int SIG_WIDTH = DEF_SIG_WIDTH
);
  logic                 bist_start;
  logic [SIG_WIDTH-1:0] sig_in;
  logic                 bist_init;
  logic                 test_mode;
  logic                 bist_end;
  logic                 pass_fail;
  logic [SIG_WIDTH-1:0] signature_o;

  // Requester side: asks for a run and supplies the chain signature
  modport master (
    output bist_start, sig_in,
    input  bist_init, test_mode, bist_end, pass_fail, signature_o
  );

  // Controller side
  modport slave (
    input  bist_start, sig_in,
    output bist_init, test_mode, bist_end, pass_fail, signature_o
  );
endinterface

// File: rtl/bist_cycle_counter.sv
// rtl/bist_cycle_counter.sv - saturating down-counter that times the RUN phase
module bist_cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);
  logic [WIDTH-1:0] cnt_q;

  // Load has priority; counting stops at zero so the value never wraps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - IDLE/INIT/RUN/COMPARE/DONE sequencer for circular BIST
module bist_controller
  import bist_pkg::*;
#(
  parameter int                   TEST_CYCLES = DEF_TEST_CYCLES,
  parameter int                   SIG_WIDTH   = DEF_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG  = SIG_WIDTH'(DEF_GOLDEN_SIG)
) (
  input logic               clock,
  input logic               reset,
  bist_controller_if.slave  bus
);
  localparam int              CNT_W    = cnt_width(TEST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TEST_CYCLES - 1);

  bist_state_e          state_q;
  logic                 start_q;
  logic                 start_evt_q;
  logic                 bist_init_q;
  logic                 test_mode_q;
  logic                 bist_end_q;
  logic                 pass_fail_q;
  logic [SIG_WIDTH-1:0] signature_q;
  logic                 cnt_zero;

  bist_cycle_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_counter (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (state_q == ST_INIT),
    .enable_i   (state_q == ST_RUN),
    .load_val_i (CNT_LOAD),
    .zero_o     (cnt_zero)
  );

  // Sequencer with registered outputs; start edge is captured only while a run may begin.
  // start_q resets to 1 so a request already high at reset release needs a low first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b1;
      start_evt_q <= 1'b0;
      bist_init_q <= 1'b0;
      test_mode_q <= 1'b0;
      bist_end_q  <= 1'b0;
      pass_fail_q <= 1'b0;
      signature_q <= '0;
    end else begin
      start_q     <= bus.bist_start;
      start_evt_q <= bus.bist_start & ~start_q &
                     ((state_q == ST_IDLE) | (state_q == ST_DONE));
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_evt_q) begin
            state_q     <= ST_INIT;
            bist_init_q <= 1'b1;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
          end
        end
        ST_INIT: begin
          state_q     <= ST_RUN;
          bist_init_q <= 1'b0;
          test_mode_q <= 1'b1;
        end
        ST_RUN: begin
          if (cnt_zero) begin
            state_q     <= ST_COMPARE;
            test_mode_q <= 1'b0;
            signature_q <= bus.sig_in;
          end
        end
        ST_COMPARE: begin
          state_q     <= ST_DONE;
          pass_fail_q <= (signature_q == GOLDEN_SIG);
          bist_end_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          bist_init_q <= 1'b0;
          test_mode_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bist_init   = bist_init_q;
  assign bus.test_mode   = test_mode_q;
  assign bus.bist_end    = bist_end_q;
  assign bus.pass_fail   = pass_fail_q;
  assign bus.signature_o = signature_q;
endmodule
